// File: rtl/seg7_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundle of the load bus and display pins of the 4-digit scan driver.
//
//   Signals:
//     load       host -> driver  capture value/dots/dig_en into pending register
//     value      host -> driver  16-bit hex value, nibble i on digit i
//     dots       host -> driver  dot (segment h) request per digit
//     dig_en     host -> driver  per-digit enable
//     pending    driver -> host  captured data not yet on the display
//     frame_tick driver -> host  one-cycle pulse at each frame end
//     abcdefgh   driver -> pins  segments, active-low (bit7 = a, bit0 = h)
//     digit      driver -> pins  digit selects, active-low (bit i = digit i)
//
//   Modports: master = host/bench side, slave = the scan driver.
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  dig_en;
    logic        pending;
    logic        frame_tick;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;

    modport master (
        output load, value, dots, dig_en,
        input  pending, frame_tick, abcdefgh, digit
    );

    modport slave (
        input  load, value, dots, dig_en,
        output pending, frame_tick, abcdefgh, digit
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//   Round-robin scan driver for a 4-digit multiplexed 7-segment display.
//   New data is captured into a pending register on `load` and moved into the
//   active (displayed) register only at a frame boundary, so a frame is never
//   drawn from a mix of old and new data. Each digit slot starts with a blank
//   window of BLANK_CYCLES to suppress ghosting while the digit select moves.
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset (synchronous release expected)
//     bus      seg7_scan_driver_if.slave (load/value/dots/dig_en in,
//              pending/frame_tick/abcdefgh/digit out)
//
//   Parameters:
//     REFRESH_DIV   clock cycles per digit slot (>= 2)
//     BLANK_CYCLES  blank cycles at the start of each slot (< REFRESH_DIV)
//
//   Optional feature:
//     SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero digits (digit 1..3
//     with all higher-or-equal nibbles zero and no dot) are blanked.
//
//   Outputs decode only registered state (cnt, idx, active registers), so the
//   async reset blanks the display immediately.
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg7_scan_driver_if.slave    bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Segment lookup, active-high, a..g in bits 7..1, bit 0 (dot) left clear.
    function automatic logic [7:0] seg_lut(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
            4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      act_val, pnd_val;
    logic [3:0]       act_dot, pnd_dot;
    logic [3:0]       act_en,  pnd_en;
    logic             pending_q;
    logic             frame_end;

    assign frame_end = (idx == 2'd3) && (cnt == CNT_LAST);

    // Scan counters, pending capture and frame-boundary transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            idx       <= 2'd0;
            act_val   <= '0;
            act_dot   <= '0;
            act_en    <= '0;
            pnd_val   <= '0;
            pnd_dot   <= '0;
            pnd_en    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // The transfer reads the old pending contents, so a load in the
            // frame_tick cycle lands in pending and keeps the flag set.
            if (frame_end && pending_q) begin
                act_val <= pnd_val;
                act_dot <= pnd_dot;
                act_en  <= pnd_en;
            end

            if (bus.load) begin
                pnd_val   <= bus.value;
                pnd_dot   <= bus.dots;
                pnd_en    <= bus.dig_en;
                pending_q <= 1'b1;
            end else if (frame_end && pending_q) begin
                pending_q <= 1'b0;
            end
        end
    end

    logic [15:0] val_shift;
    logic [3:0]  cur_nib;
    logic        cur_dot;
    logic        lz_blank;
    logic        lit;

    always_comb begin
        val_shift = act_val >> {idx, 2'b00};
        cur_nib   = val_shift[3:0];
        cur_dot   = act_dot[idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Digit 0 always shows, so a value of zero still reads "0".
        case (idx)
            2'd1:    lz_blank = (act_val[15:4]  == 12'h000) && !act_dot[1];
            2'd2:    lz_blank = (act_val[15:8]  == 8'h00)   && !act_dot[2];
            2'd3:    lz_blank = (act_val[15:12] == 4'h0)    && !act_dot[3];
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif

        lit = (cnt >= BLANK_END) && act_en[idx] && !lz_blank;

        if (lit) begin
            bus.digit    = ~(4'b0001 << idx);
            bus.abcdefgh = ~(seg_lut(cur_nib) | {7'b0, cur_dot});
        end else begin
            bus.digit    = 4'hF;
            bus.abcdefgh = 8'hFF;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed and randomized stimulus for seg7_scan_driver (REFRESH_DIV = 8,
//   BLANK_CYCLES = 2). The reference model tracks elapsed cycles since reset
//   release and derives slot, position within slot and frame boundaries with
//   plain arithmetic; it holds displayed and pending data as simple variables.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          t;
    logic [15:0] m_act_val, m_pnd_val;
    logic [3:0]  m_act_dot, m_pnd_dot;
    logic [3:0]  m_act_en,  m_pnd_en;
    logic        m_pend;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        m_act_val = '0; m_act_dot = '0; m_act_en = '0;
        m_pnd_val = '0; m_pnd_dot = '0; m_pnd_en = '0;
        m_pend    = 1'b0;
    endtask

    task automatic check_outputs();
        int         pos, slot;
        logic       on;
        logic [3:0] nib;
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        pos  = t % RD;
        slot = (t / RD) % 4;
        nib  = 4'((m_act_val >> (4 * slot)) & 16'hF);
        on   = (pos >= BC) && m_act_en[slot];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot != 0 && (m_act_val >> (4 * slot)) == 16'h0 && !m_act_dot[slot])
            on = 1'b0;
`endif
        exp_dig = on ? ~(4'b0001 << slot) : 4'hF;
        exp_seg = on ? ~(seg_tab[nib] | {7'b0, m_act_dot[slot]}) : 8'hFF;
        check("digit",      {12'b0, bus.digit},      {12'b0, exp_dig});
        check("abcdefgh",   {8'b0,  bus.abcdefgh},   {8'b0,  exp_seg});
        check("frame_tick", {15'b0, bus.frame_tick}, {15'b0, 1'((t % FRAME) == FRAME - 1)});
        check("pending",    {15'b0, bus.pending},    {15'b0, m_pend});
    endtask

    // One clock: drive inputs, check outputs, advance model, step to next negedge.
    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] e);
        bus.load   = ld;
        bus.value  = v;
        bus.dots   = d;
        bus.dig_en = e;
        check_outputs();
        if ((t % FRAME) == FRAME - 1 && m_pend) begin
            m_act_val = m_pnd_val;
            m_act_dot = m_pnd_dot;
            m_act_en  = m_pnd_en;
            m_pend    = 1'b0;
        end
        if (ld) begin
            m_pnd_val = v;
            m_pnd_dot = d;
            m_pnd_en  = e;
            m_pend    = 1'b1;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic check_blank_reset();
        check("rst_digit",      {12'b0, bus.digit},      16'h000F);
        check("rst_abcdefgh",   {8'b0,  bus.abcdefgh},   16'h00FF);
        check("rst_pending",    {15'b0, bus.pending},    16'h0000);
        check("rst_frame_tick", {15'b0, bus.frame_tick}, 16'h0000);
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.value  = '0;
        bus.dots   = '0;
        bus.dig_en = '0;
        model_reset();

        // Reset and release, display blank with no load
        #2 reset_n = 1'b0;
        #1 check_blank_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_blank_reset();
        reset_n = 1'b1;
        model_reset();
        idle(70);

        // 1234, all digits enabled
        cycle(1'b1, 16'h1234, 4'h0, 4'hF);
        idle(2 * FRAME);

        // ABCD with dot on digit 0, digits 0 and 2 enabled
        cycle(1'b1, 16'hABCD, 4'b0001, 4'b0101);
        idle(2 * FRAME);

        // Overwrite pending, then a load coincident with frame_tick
        while ((t % FRAME) != 0) idle(1);
        cycle(1'b1, 16'h1111, 4'h0, 4'hF);
        idle(5);
        cycle(1'b1, 16'h2222, 4'h0, 4'hF);
        while ((t % FRAME) != FRAME - 1) idle(1);
        cycle(1'b1, 16'h3333, 4'h0, 4'hF);
        idle(2 * FRAME);

        // Load in the frame_tick cycle while nothing is pending
        while ((t % FRAME) != FRAME - 1) idle(1);
        cycle(1'b1, 16'h5678, 4'b1010, 4'hF);
        idle(2 * FRAME);

        // Async reset mid-slot while digit 2 is lit
        while (!(((t / RD) % 4) == 2 && (t % RD) == 4)) idle(1);
        check("pre_rst_digit", {12'b0, bus.digit}, 16'h000B);
        #1 reset_n = 1'b0;
        #1 check_blank_reset();
        @(negedge clk);
        check_blank_reset();
        reset_n = 1'b1;
        model_reset();
        idle(70);

        // Leading zeros
        cycle(1'b1, 16'h0050, 4'h0, 4'hF);
        idle(2 * FRAME);
        cycle(1'b1, 16'h0000, 4'h0, 4'hF);
        idle(2 * FRAME);

        // Randomized loads
        repeat (600) begin
            cycle(1'($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
        end
        idle(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
